// File: rtl/byte_strip_if.sv
// Byte-stream input and 4-lane word output bundle for byte_strip.
// The master side drives the byte stream; the slave side produces the words.
interface byte_strip_if;
  logic [7:0] D;
  logic       DK;
  logic       VALID_IN;
  logic [7:0] LANE0;
  logic [7:0] LANE1;
  logic [7:0] LANE2;
  logic [7:0] LANE3;
  logic       DK_0;
  logic       DK_1;
  logic       DK_2;
  logic       DK_3;
  logic       VALID_OUT;
  logic       PADDED;
  logic [1:0] FILL_LEVEL;

  modport master (
    output D, DK, VALID_IN,
    input  LANE0, LANE1, LANE2, LANE3, DK_0, DK_1, DK_2, DK_3,
    input  VALID_OUT, PADDED, FILL_LEVEL
  );

  modport slave (
    input  D, DK, VALID_IN,
    output LANE0, LANE1, LANE2, LANE3, DK_0, DK_1, DK_2, DK_3,
    output VALID_OUT, PADDED, FILL_LEVEL
  );
endinterface

// File: rtl/byte_strip.sv
// Stripes a serial byte stream round-robin into aligned 4-lane words, padding
// a stalled partial word with control bytes so no torn word ever leaves.
module byte_strip #(
  parameter logic [7:0] PAD_BYTE    = 8'hF7,
  parameter int         PAD_TIMEOUT = 8,
  parameter int         CNT_W       = 8
) (
  input  logic         CLK,
  input  logic         RESET_L,
  byte_strip_if.slave  bus
);

  localparam logic [0:0]       ST_EMPTY   = 1'b0;
  localparam logic [0:0]       ST_FILLING = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PAD_TIMEOUT - 1);

  logic [0:0]       state_q, state_d;
  logic [1:0]       fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             padded_q, padded_d;
  // Entries are {dk, byte}; the fourth byte never needs staging.
  logic [8:0]       stage_q [3];
  logic [8:0]       stage_d [3];
  logic [8:0]       lane_q  [4];
  logic [8:0]       lane_d  [4];
  logic [8:0]       in_byte;
  logic             complete;
  logic             flush;

  assign in_byte = {bus.DK, bus.D};

  always_comb begin
    complete = bus.VALID_IN && (fill_q == 2'd3);
    // An arriving byte always beats the timeout.
    flush    = (PAD_TIMEOUT != 0) && (state_q == ST_FILLING) &&
               !bus.VALID_IN && (cnt_q == CNT_LAST);

    fill_d = fill_q;
    if (bus.VALID_IN) begin
      fill_d = fill_q + 2'd1;
    end else if (flush) begin
      fill_d = 2'd0;
    end
    state_d = (fill_d == 2'd0) ? ST_EMPTY : ST_FILLING;

    cnt_d = cnt_q;
    if (bus.VALID_IN || (state_q == ST_EMPTY) || flush) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    valid_d  = complete || flush;
    padded_d = flush;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_stage
      assign stage_d[gi] = (bus.VALID_IN && (fill_q == 2'(gi))) ? in_byte : stage_q[gi];
    end

    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [8:0] word_byte;
      if (gi < 3) begin : g_staged
        // On completion fill_q is 3, so every staged lane qualifies.
        assign word_byte = (fill_q > 2'(gi)) ? stage_q[gi] : {1'b1, PAD_BYTE};
      end else begin : g_last
        assign word_byte = complete ? in_byte : {1'b1, PAD_BYTE};
      end
      assign lane_d[gi] = (complete || flush) ? word_byte : lane_q[gi];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      state_q  <= ST_EMPTY;
      fill_q   <= 2'd0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      padded_q <= 1'b0;
      for (int i = 0; i < 3; i++) stage_q[i] <= '0;
      for (int i = 0; i < 4; i++) lane_q[i]  <= '0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      padded_q <= padded_d;
      for (int i = 0; i < 3; i++) stage_q[i] <= stage_d[i];
      for (int i = 0; i < 4; i++) lane_q[i]  <= lane_d[i];
    end
  end

  assign bus.LANE0      = lane_q[0][7:0];
  assign bus.LANE1      = lane_q[1][7:0];
  assign bus.LANE2      = lane_q[2][7:0];
  assign bus.LANE3      = lane_q[3][7:0];
  assign bus.DK_0       = lane_q[0][8];
  assign bus.DK_1       = lane_q[1][8];
  assign bus.DK_2       = lane_q[2][8];
  assign bus.DK_3       = lane_q[3][8];
  assign bus.VALID_OUT  = valid_q;
  assign bus.PADDED     = padded_q;
  assign bus.FILL_LEVEL = fill_q;

endmodule

// File: tb/tb_byte_strip.sv
// Scoreboard bench for byte_strip: a timeout-8 instance and a timeout-disabled
// instance, directed byte vectors, expected words queued when stimulus is issued.
module tb_byte_strip;

  logic clk = 1'b0;
  logic rst_l;
  always #5 clk = ~clk;

  byte_strip_if bus8 ();
  byte_strip_if bus0 ();

  byte_strip #(.PAD_BYTE(8'hF7), .PAD_TIMEOUT(8), .CNT_W(8)) dut8 (
    .CLK(clk), .RESET_L(rst_l), .bus(bus8)
  );
  byte_strip #(.PAD_BYTE(8'hF7), .PAD_TIMEOUT(0), .CNT_W(8)) dut0 (
    .CLK(clk), .RESET_L(rst_l), .bus(bus0)
  );

  typedef struct {
    logic [31:0] lanes;   // {LANE3, LANE2, LANE1, LANE0}
    logic [3:0]  dks;     // {DK_3, DK_2, DK_1, DK_0}
    logic        padded;
    int          cyc;     // cycle count at which VALID_OUT must be seen
  } exp_t;

  exp_t q8[$];
  exp_t q0[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] w(input logic [7:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic check_word(input string nm, input logic [31:0] lanes, input logic [3:0] dks,
                            input logic padded, input bit have, input exp_t e);
    if (!have) begin
      tests++;
      fails++;
      $display("FAIL %s unexpected word: lanes=%h dk=%b padded=%b cycle %0d",
               nm, lanes, dks, padded, cyc);
    end else begin
      $display("[TB] %s word lanes=%h dk=%b padded=%b cycle %0d", nm, lanes, dks, padded, cyc);
      chk({nm, " lanes"},  64'(lanes),  64'(e.lanes));
      chk({nm, " dk"},     64'(dks),    64'(e.dks));
      chk({nm, " padded"}, 64'(padded), 64'(e.padded));
      chk({nm, " cycle"},  64'(cyc),    64'(e.cyc));
    end
  endtask

  always @(negedge clk) begin : mon8
    exp_t e;
    bit   have;
    if (bus8.VALID_OUT) begin
      have = (q8.size() > 0);
      if (have) e = q8.pop_front();
      else e = '{lanes: '0, dks: '0, padded: 1'b0, cyc: 0};
      check_word("dut8", {bus8.LANE3, bus8.LANE2, bus8.LANE1, bus8.LANE0},
                 {bus8.DK_3, bus8.DK_2, bus8.DK_1, bus8.DK_0}, bus8.PADDED, have, e);
    end else if (bus8.PADDED) begin
      chk("dut8 padded_without_valid", 64'(bus8.PADDED), 64'(0));
    end
  end

  always @(negedge clk) begin : mon0
    exp_t e;
    bit   have;
    if (bus0.VALID_OUT) begin
      have = (q0.size() > 0);
      if (have) e = q0.pop_front();
      else e = '{lanes: '0, dks: '0, padded: 1'b0, cyc: 0};
      check_word("dut0", {bus0.LANE3, bus0.LANE2, bus0.LANE1, bus0.LANE0},
                 {bus0.DK_3, bus0.DK_2, bus0.DK_1, bus0.DK_0}, bus0.PADDED, have, e);
    end else if (bus0.PADDED) begin
      chk("dut0 padded_without_valid", 64'(bus0.PADDED), 64'(0));
    end
  end

  // Called at a falling edge; the byte is sampled on the next rising edge.
  task automatic send8(input logic [7:0] b, input logic k);
    bus8.D = b; bus8.DK = k; bus8.VALID_IN = 1'b1;
    @(negedge clk);
    bus8.VALID_IN = 1'b0;
  endtask

  task automatic send0(input logic [7:0] b, input logic k);
    bus0.D = b; bus0.DK = k; bus0.VALID_IN = 1'b1;
    @(negedge clk);
    bus0.VALID_IN = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect8(input logic [31:0] l, input logic [3:0] k, input logic p, input int dly);
    q8.push_back('{lanes: l, dks: k, padded: p, cyc: cyc + dly});
  endtask

  task automatic expect0(input logic [31:0] l, input logic [3:0] k, input logic p, input int dly);
    q0.push_back('{lanes: l, dks: k, padded: p, cyc: cyc + dly});
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst_l = 1'b0;
    bus8.D = 8'h00; bus8.DK = 1'b0; bus8.VALID_IN = 1'b0;
    bus0.D = 8'h00; bus0.DK = 1'b0; bus0.VALID_IN = 1'b0;
    idle(3);

    chk("reset lanes",  64'({bus8.LANE3, bus8.LANE2, bus8.LANE1, bus8.LANE0}), 64'(0));
    chk("reset dk",     64'({bus8.DK_3, bus8.DK_2, bus8.DK_1, bus8.DK_0}), 64'(0));
    chk("reset valid",  64'(bus8.VALID_OUT), 64'(0));
    chk("reset padded", 64'(bus8.PADDED), 64'(0));
    chk("reset fill",   64'(bus8.FILL_LEVEL), 64'(0));
    chk("reset dut0 lanes", 64'({bus0.LANE3, bus0.LANE2, bus0.LANE1, bus0.LANE0}), 64'(0));
    chk("reset dut0 fill",  64'(bus0.FILL_LEVEL), 64'(0));
    rst_l = 1'b1;
    idle(1);

    // Basic word, then outputs must hold after the strobe.
    send8(8'h11, 1'b0);
    send8(8'h22, 1'b0);
    send8(8'h33, 1'b0);
    chk("fill after 3 bytes", 64'(bus8.FILL_LEVEL), 64'(3));
    expect8(w(8'h11, 8'h22, 8'h33, 8'h44), 4'b0000, 1'b0, 1);
    send8(8'h44, 1'b0);
    chk("fill after word", 64'(bus8.FILL_LEVEL), 64'(0));
    idle(12);
    chk("lanes hold", 64'({bus8.LANE3, bus8.LANE2, bus8.LANE1, bus8.LANE0}),
        64'(w(8'h11, 8'h22, 8'h33, 8'h44)));

    // Twelve back-to-back bytes, control flag on 0x05 only.
    expect8(w(8'h01, 8'h02, 8'h03, 8'h04), 4'b0000, 1'b0, 4);
    expect8(w(8'h05, 8'h06, 8'h07, 8'h08), 4'b0001, 1'b0, 8);
    expect8(w(8'h09, 8'h0A, 8'h0B, 8'h0C), 4'b0000, 1'b0, 12);
    for (int i = 1; i <= 12; i++) begin
      send8(8'(i), (i == 5));
    end
    idle(2);

    // Timeout flush after two bytes: flush on the 8th idle edge.
    send8(8'hA1, 1'b0);
    expect8(w(8'hA1, 8'hA2, 8'hF7, 8'hF7), 4'b1100, 1'b1, 9);
    send8(8'hA2, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      chk($sformatf("fill hold idle %0d", i), 64'(bus8.FILL_LEVEL), 64'(2));
      idle(1);
    end
    chk("fill hold idle 7 end", 64'(bus8.FILL_LEVEL), 64'(2));
    idle(1);
    chk("fill after flush", 64'(bus8.FILL_LEVEL), 64'(0));
    idle(3);

    // A byte arriving on the timeout cycle wins over the flush.
    send8(8'hB1, 1'b0);
    idle(7);
    send8(8'hB2, 1'b0);
    chk("fill byte beats timeout", 64'(bus8.FILL_LEVEL), 64'(2));
    send8(8'hB3, 1'b0);
    expect8(w(8'hB1, 8'hB2, 8'hB3, 8'hB4), 4'b0000, 1'b0, 1);
    send8(8'hB4, 1'b0);
    idle(2);

    // Data bytes equal to the pad value are ordinary data.
    send8(8'hF7, 1'b0);
    send8(8'h00, 1'b0);
    send8(8'hF7, 1'b0);
    expect8(w(8'hF7, 8'h00, 8'hF7, 8'h12), 4'b0000, 1'b0, 1);
    send8(8'h12, 1'b0);
    idle(2);

    // Reset mid-word discards staged bytes.
    send8(8'hC1, 1'b0);
    send8(8'hC2, 1'b0);
    send8(8'hC3, 1'b0);
    rst_l = 1'b0;
    idle(1);
    chk("midreset lanes", 64'({bus8.LANE3, bus8.LANE2, bus8.LANE1, bus8.LANE0}), 64'(0));
    chk("midreset dk",    64'({bus8.DK_3, bus8.DK_2, bus8.DK_1, bus8.DK_0}), 64'(0));
    chk("midreset valid", 64'(bus8.VALID_OUT), 64'(0));
    chk("midreset fill",  64'(bus8.FILL_LEVEL), 64'(0));
    rst_l = 1'b1;
    send8(8'hD1, 1'b0);
    send8(8'hD2, 1'b0);
    send8(8'hD3, 1'b0);
    expect8(w(8'hD1, 8'hD2, 8'hD3, 8'hD4), 4'b0000, 1'b0, 1);
    send8(8'hD4, 1'b0);
    idle(2);

    // Timeout disabled: a lone byte waits indefinitely.
    send0(8'hE1, 1'b0);
    chk("dut0 fill after E1", 64'(bus0.FILL_LEVEL), 64'(1));
    idle(300);
    chk("dut0 fill after 300 idle", 64'(bus0.FILL_LEVEL), 64'(1));
    send0(8'hE2, 1'b0);
    send0(8'hE3, 1'b0);
    expect0(w(8'hE1, 8'hE2, 8'hE3, 8'hE4), 4'b0000, 1'b0, 1);
    send0(8'hE4, 1'b0);
    idle(20);

    chk("dut8 words all seen", 64'(q8.size()), 64'(0));
    chk("dut0 words all seen", 64'(q0.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/byte_strip.md
Name: byte_strip

Overview:
- Upstream counterpart of the 4-lane unstriping stage.
- Accepts a serial byte stream with a per-byte data/control flag and distributes consecutive bytes round-robin across LANE0..LANE3.
- Emits an aligned 4-lane word with one-cycle valid strobe once all four lanes are filled.
- A partially filled word that stalls for PAD_TIMEOUT cycles is completed with control-pad bytes and emitted, so the downstream unstriper never sees a torn word.

Parameters:
- PAD_BYTE, 8'hF7, byte placed in unfilled lanes on timeout flush (always flagged as control, DK_n=1)
- PAD_TIMEOUT, 8, idle cycles with partial word before flush; 0 disables flush
- CNT_W, 8, width of idle counter; must satisfy PAD_TIMEOUT < 2**CNT_W

Ports:
- CLK  input  1  single clock, all state updates on rising edge
- RESET_L  input  1  synchronous active-low reset, sampled on rising CLK
- D  input  8  input byte
- DK  input  1  input control flag (1 = K/control byte, 0 = data)
- VALID_IN  input  1  D/DK valid this cycle; block always accepts (no backpressure)
- LANE0..LANE3  output  8 each  lane bytes of last emitted word; LANE0 = first byte received
- DK_0..DK_3  output  1 each  control flag for corresponding lane
- VALID_OUT  output  1  one-cycle strobe: LANE*/DK_* hold a new word
- PADDED  output  1  asserted with VALID_OUT when word was completed by timeout flush
- FILL_LEVEL  output  2  number of bytes currently staged (0..3)

Behaviour:
- Reset (RESET_L=0 at rising CLK): LANE0..3=8'h00, DK_0..3=0, VALID_OUT=0, PADDED=0, FILL_LEVEL=0, idle counter=0, staging cleared, FSM to EMPTY. Reset mid-word discards staged bytes; nothing emitted.
- FSM states: EMPTY (FILL_LEVEL=0), FILLING (1..3 staged). Emission is a registered action, not a state.
- Accept: VALID_IN=1 writes {DK,D} into stage[FILL_LEVEL]; FILL_LEVEL increments mod 4.
- Word complete: byte accepted while FILL_LEVEL=3 → on that same edge, LANE0..2/DK_0..2 load stage[0..2], LANE3/DK_3 load the incoming byte, VALID_OUT=1, PADDED=0, FILL_LEVEL→0, FSM→EMPTY. Latency: fourth byte sampled at edge N is visible on LANE3 after edge N (registered, 1 cycle).
- Back-to-back: continuous VALID_IN gives VALID_OUT every 4th cycle; the byte after a completing byte goes into stage[0] with no bubble.
- Outputs LANE*/DK_* hold the last word while VALID_OUT=0; VALID_OUT and PADDED are single-cycle pulses.
- Idle counter: cleared whenever VALID_IN=1 or FSM=EMPTY. Increments (saturating at 2**CNT_W-1) each cycle in FILLING with VALID_IN=0.
- Timeout flush: in FILLING with VALID_IN=0 and counter == PAD_TIMEOUT-1 → on that edge emit staged lanes [0..FILL_LEVEL-1] unchanged, lanes [FILL_LEVEL..3] = PAD_BYTE with DK_n=1, VALID_OUT=1, PADDED=1, FILL_LEVEL→0, counter→0. So flush occurs exactly PAD_TIMEOUT idle cycles after the last accepted byte.
- Simultaneous timeout and VALID_IN=1: the byte wins. It is accepted normally, counter clears, no flush.
- PAD_TIMEOUT=0: flush never occurs; partial word waits indefinitely.
- EMPTY with VALID_IN=0: no action, no flush, counter stays 0.
- DK is carried transparently; a user byte equal to PAD_BYTE with DK=0 is ordinary data.
- Round-robin order is fixed: lane index = byte position in word; no lane skipping.

Test Plan:
- Reset then bytes 8'h11,22,33,44 (DK=0) on 4 consecutive cycles → one cycle after 8'h44 sampled: LANE0..3=11,22,33,44, DK_0..3=0, VALID_OUT=1 for exactly 1 cycle, PADDED=0, FILL_LEVEL=0.
- 12 continuous bytes 8'h01..8'h0C, DK=1 on 8'h05 only → VALID_OUT pulses 3 times, 4 cycles apart. Words {01,02,03,04}, {05,06,07,08} with DK_0=1 in second word only, {09,0A,0B,0C}.
- Bytes 8'hA1,A2 then VALID_IN=0, PAD_TIMEOUT=8 → FILL_LEVEL=2 for 7 idle cycles, then on 8th idle edge VALID_OUT=1, PADDED=1, LANE0..3=A1,A2,F7,F7, DK_0..3=0,0,1,1.
- Byte 8'hB1, 7 idle cycles, then 8'hB2 on the cycle timeout would fire, then 8'hB3,B4 → no PADDED pulse; single word {B1,B2,B3,B4} with PADDED=0.
- Bytes 8'hC1,C2,C3, RESET_L=0 one cycle, then 8'hD1..D4 → no VALID_OUT for C bytes; outputs 0 during reset; next word exactly {D1,D2,D3,D4}.
- PAD_TIMEOUT=0 build: byte 8'hE1 then 300 idle cycles → VALID_OUT stays 0, FILL_LEVEL stays 1. Three more bytes then emit {E1,...} with PADDED=0.
